// File: rtl/accum_pkg.sv
// Shared FP32 constants, FSM states and small
// FP32 classification helpers for accum_stream.
package accum_pkg;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    COLLECT,
    REDUCE,
    DONE
  } accum_state_t;

  function automatic logic fp_is_nan(
    input logic [31:0] x
  );
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic fp_is_inf(
    input logic [31:0] x
  );
    return (&x[30:23]) && !(|x[22:0]);
  endfunction

  function automatic logic fp_is_zero(
    input logic [31:0] x
  );
    return !(|x[30:0]);
  endfunction

  // Subnormals are treated as +0.0 everywhere.
  function automatic logic [31:0] fp_ftz(
    input logic [31:0] x
  );
    if (x[30:23] == 8'd0 && |x[22:0])
      return FP_POS_ZERO;
    return x;
  endfunction

endpackage

// File: rtl/fp_add_pipe.sv
// FP32 adder (RNE, flush-to-zero) followed by a
// fixed ADD_LAT-stage register pipeline.
module fp_add_pipe
  import accum_pkg::*;
#(
  parameter int ADD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] result
);

  function automatic logic [31:0] fp_add(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] a, b, t, r;
    logic [26:0] ma, mb, sh, nrm;
    logic [27:0] sm;
    logic [7:0]  d;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic        stk, up;
    a = fp_ftz(x);
    b = fp_ftz(y);
    r = FP_POS_ZERO;
    if (fp_is_nan(a) || fp_is_nan(b)) begin
      r = FP_QNAN;
    end else if (fp_is_inf(a) && fp_is_inf(b)) begin
      r = (a[31] != b[31]) ? FP_QNAN : a;
    end else if (fp_is_inf(a)) begin
      r = a;
    end else if (fp_is_inf(b)) begin
      r = b;
    end else if (fp_is_zero(a) && fp_is_zero(b)) begin
      r = {a[31] & b[31], 31'd0};
    end else if (fp_is_zero(a)) begin
      r = b;
    end else if (fp_is_zero(b)) begin
      r = a;
    end else begin
      if (b[30:0] > a[30:0]) begin
        t = a;
        a = b;
        b = t;
      end
      d  = a[30:23] - b[30:23];
      ma = {1'b1, a[22:0], 3'b000};
      mb = {1'b1, b[22:0], 3'b000};
      if (d > 8'd26) begin
        sh = 27'd1;
      end else begin
        sh = mb >> d;
        stk = |(mb & ~(27'h7FF_FFFF << d));
        sh[0] = sh[0] | stk;
      end
      e = {2'b00, a[30:23]};
      if (a[31] == b[31]) begin
        sm = {1'b0, ma} + {1'b0, sh};
        if (sm[27]) begin
          nrm = sm[27:1];
          nrm[0] = nrm[0] | sm[0];
          e = e + 10'd1;
        end else begin
          nrm = sm[26:0];
        end
      end else begin
        nrm = ma - sh;
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
          if (nrm[i]) lz = 5'(26 - i);
        nrm = nrm << lz;
        e = e - {5'd0, lz};
      end
      if (nrm == 27'd0 || e[9] || e == 10'd0) begin
        r = FP_POS_ZERO;
      end else if (e >= 10'd255) begin
        r = {a[31], 8'hFF, 23'd0};
      end else begin
        // Mantissa carry ripples into the exponent.
        up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        r = {a[31], {e[7:0], nrm[25:3]} + {30'd0, up}};
      end
    end
    return r;
  endfunction

  logic [31:0] stg_q [ADD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ADD_LAT; i++)
        stg_q[i] <= FP_POS_ZERO;
    end else if (en) begin
      stg_q[0] <= fp_add(a_in, b_in);
      for (int i = 1; i < ADD_LAT; i++)
        stg_q[i] <= stg_q[i-1];
    end
  end

  assign result = stg_q[ADD_LAT-1];

endmodule

// File: rtl/accum_stream.sv
// Full-throughput FP32 frame accumulator: ADD_LAT partial
// sums circulate in the adder, then get reduced to one.
module accum_stream
  import accum_pkg::*;
#(
  parameter int ADD_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam logic [3:0] SUB_LAST = 4'(ADD_LAT - 1);
  localparam logic [2:0] K_LAST   = 3'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  accum_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      buf_q [8];
  logic [3:0]       sub_q;
  logic [2:0]       k_q;
  logic             xfer, out_fire, sub_end;
  logic             pipe_rst, pipe_en;
  logic [31:0]      add_a, add_b, sum;

  assign in_ready = !rst &&
    (state_q == IDLE || state_q == ACCUM);
  assign xfer      = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign out_fire  = out_valid && out_ready;
  assign busy      = state_q != IDLE;
  assign sub_end   = sub_q == SUB_LAST;
  assign out_count = cnt_q;

  // The pipeline is frozen in DONE so its output
  // holds the final sum until the handshake.
  assign pipe_en  = state_q != DONE;
  assign pipe_rst = rst || clr || out_fire;

  assign out_data = !out_valid ? FP_POS_ZERO :
    (ADD_LAT == 1) ? buf_q[0] : sum;

  fp_add_pipe #(
    .ADD_LAT (ADD_LAT)
  ) u_add (
    .clk    (clk),
    .rst    (pipe_rst),
    .en     (pipe_en),
    .a_in   (add_a),
    .b_in   (add_b),
    .result (sum)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (xfer)
          state_d = in_last ? COLLECT : ACCUM;
      ACCUM:
        if (xfer && in_last)
          state_d = COLLECT;
      COLLECT:
        if (sub_end)
          state_d = (ADD_LAT == 1) ? DONE : REDUCE;
      REDUCE:
        if (sub_end && k_q == K_LAST)
          state_d = DONE;
      DONE:
        if (out_ready)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
    if (clr)
      state_d = IDLE;
  end

  always_comb begin
    add_a = FP_POS_ZERO;
    add_b = FP_POS_ZERO;
    unique case (state_q)
      IDLE, ACCUM: begin
        add_a = xfer ? in_data : FP_POS_ZERO;
        add_b = sum;
      end
      REDUCE:
        if (sub_q == 4'd0) begin
          add_a = (k_q == 3'd1) ? buf_q[0] : sum;
          add_b = buf_q[k_q];
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
      sub_q <= 4'd0;
      k_q   <= 3'd1;
      for (int i = 0; i < 8; i++)
        buf_q[i] <= FP_POS_ZERO;
    end else begin
      if (out_fire)
        cnt_q <= '0;
      else if (xfer && state_q == IDLE)
        cnt_q <= CNT_ONE;
      else if (xfer && !(&cnt_q))
        cnt_q <= cnt_q + CNT_ONE;
      if (state_q == COLLECT)
        buf_q[sub_q[2:0]] <= sum;
      if (state_q == COLLECT || state_q == REDUCE) begin
        sub_q <= sub_end ? 4'd0 : sub_q + 4'd1;
        if (state_q == REDUCE && sub_end)
          k_q <= k_q + 3'd1;
      end else begin
        sub_q <= 4'd0;
        k_q   <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_accum_stream.sv
// Randomized and directed checks of accum_stream
// against an integer-sum reference model.
module tb_accum_stream;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        in_valid, in_ready, in_last;
  logic        out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic [15:0] out_count;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] fr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accum_stream #(
    .ADD_LAT (L),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
        tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Exact FP32 encoding of a small integer.
  function automatic logic [31:0] i2f(input int v);
    int m, p;
    logic s;
    if (v == 0) return 32'h0;
    s = v < 0;
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++)
      if ((m >> i) != 0) p = i;
    return {s, 8'(127 + p),
      23'((m << (23 - p)) & 32'h7F_FFFF)};
  endfunction

  task automatic run_frame(
    input string       tag,
    input logic [31:0] exp_d,
    input int          gap_pct,
    input int          hold,
    input bit          nan_exp
  );
    int t_last, n, w;
    logic is_nan;
    n = fr.size();
    t_last = cyc;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 4 &&
           $urandom_range(0, 99) < gap_pct; g++) begin
        in_valid = 1'b0;
        in_last = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data = fr[i];
      in_last = (i == n - 1);
      chk({tag, "_irdy"}, 32'(in_ready), 1);
      t_last = cyc;
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      chk({tag, "_irdy_busy"}, 32'(in_ready), 0);
      step();
      w++;
    end
    chk({tag, "_ovld"}, 32'(out_valid), 1);
    chk({tag, "_lat"}, cyc - t_last, L * L + 1);
    for (int h = 0; h <= hold; h++) begin
      is_nan = (&out_data[30:23]) && (|out_data[22:0]);
      if (nan_exp)
        chk({tag, "_nan"}, 32'(is_nan), 1);
      else
        chk({tag, "_data"}, out_data, exp_d);
      chk({tag, "_cnt"}, 32'(out_count), n);
      chk({tag, "_irdy_done"}, 32'(in_ready), 0);
      chk({tag, "_ovld_hold"}, 32'(out_valid), 1);
      if (h < hold) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ovld_clr"}, 32'(out_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_irdy_idle"}, 32'(in_ready), 1);
    chk({tag, "_cnt_clr"}, 32'(out_count), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n, v, sum;
    rst = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 32'h0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_ovld", 32'(out_valid), 0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_cnt", 32'(out_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irdy", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("irdy_after_rst", 32'(in_ready), 1);
    step();

    fr.delete();
    fr.push_back(32'h4040_0000);
    run_frame("one", 32'h4040_0000, 0, 0, 0);

    fr.delete();
    for (int i = 1; i <= 10; i++)
      fr.push_back(i2f(i));
    run_frame("ten", 32'h425C_0000, 0, 0, 0);
    run_frame("gap", 32'h425C_0000, 30, 20, 0);

    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data = i2f(i);
      in_last = 1'b0;
      step();
    end
    clr = 1'b1;
    in_data = i2f(9);
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", 32'(busy), 0);
    chk("clr_cnt", 32'(out_count), 0);
    chk("clr_ovld", 32'(out_valid), 0);
    fr.delete();
    fr.push_back(32'h4000_0000);
    fr.push_back(32'h4000_0000);
    run_frame("clr", 32'h4080_0000, 0, 0, 0);

    fr.delete();
    fr.push_back(32'h7F80_0000);
    fr.push_back(32'h3F80_0000);
    fr.push_back(32'h7FC0_0000);
    run_frame("nan", 32'h0, 0, 0, 1);

    fr.delete();
    fr.push_back(32'h8000_0000);
    run_frame("negz", 32'h0000_0000, 0, 0, 0);

    in_valid = 1'b1;
    in_data = 32'h4040_0000;
    in_last = 1'b1;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (7) step();
    chk("red_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    chk("rr_ovld", 32'(out_valid), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_irdy", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("rr_irdy_after", 32'(in_ready), 1);
    step();
    fr.delete();
    fr.push_back(32'h40A0_0000);
    run_frame("post_rst", 32'h40A0_0000, 0, 0, 0);

    repeat (8) begin
      fr.delete();
      sum = 0;
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        v = int'($urandom_range(0, 200)) - 100;
        sum += v;
        fr.push_back(i2f(v));
      end
      run_frame("rnd", i2f(sum),
        int'($urandom_range(0, 40)),
        int'($urandom_range(0, 5)), 0);
    end

    $display("Result: errors=%0d of %0d checks",
      n_err, n_chk);
    $finish;
  end

endmodule
